// File: rtl/scoreboard_reg_file_if.sv
// Register-file/scoreboard bus: read ports, issue, writeback and flush toward the file; data, busy and count back.
// The master drives the requests and the slave (the register file) returns combinational read results.
interface scoreboard_reg_file_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_W     = 5,
   parameter int READ_PORTS = 2
);
   logic [READ_PORTS-1:0][ADDR_W-1:0]     rs_in;
   logic [READ_PORTS-1:0][DATA_WIDTH-1:0] regData_out;
   logic [READ_PORTS-1:0]                 rsBusy_out;
   logic                                  issue_ctrl;
   logic [ADDR_W-1:0]                     issue_rd_in;
   logic                                  regWrite_ctrl;
   logic [ADDR_W-1:0]                     rd_in;
   logic [DATA_WIDTH-1:0]                 writeData_in;
   logic                                  flush_ctrl;
   logic [ADDR_W:0]                       busyCount_out;

   modport master (
      output rs_in, issue_ctrl, issue_rd_in, regWrite_ctrl, rd_in, writeData_in, flush_ctrl,
      input  regData_out, rsBusy_out, busyCount_out
   );

   modport slave (
      input  rs_in, issue_ctrl, issue_rd_in, regWrite_ctrl, rd_in, writeData_in, flush_ctrl,
      output regData_out, rsBusy_out, busyCount_out
   );
endinterface

// File: rtl/scoreboard_reg_file.sv
// Register file with per-register pending-write scoreboard; reads are zero-latency, updates land on the next edge.
// No backpressure: every issue, writeback and flush is accepted in the cycle it is presented.
module scoreboard_reg_file #(
   parameter int DATA_WIDTH_POW = 6,
   parameter int DATA_WIDTH     = 1 << DATA_WIDTH_POW,
   parameter int GEN_REG_COUNT  = 32,
   parameter int READ_PORTS     = 2,
   parameter int BYPASS_EN      = 1
) (
   input  logic                 clk_in,
   input  logic                 reset,
   scoreboard_reg_file_if.slave bus
);
   localparam int ADDR_W = $clog2(GEN_REG_COUNT);

   logic [DATA_WIDTH-1:0]    regs_q [GEN_REG_COUNT];
   logic [GEN_REG_COUNT-1:0] busy_q;
   logic [GEN_REG_COUNT-1:0] busy_nxt;
   logic                     wb_vld;
   logic [ADDR_W:0]          busy_cnt;

   // x0 is hardwired: writebacks to it are dropped entirely
   assign wb_vld = bus.regWrite_ctrl && (bus.rd_in != '0);

   // Writeback clears before issue sets so a same-cycle issue to the same register wins; flush beats both
   always_comb begin
      busy_nxt = busy_q;
      if (wb_vld) begin
         busy_nxt[bus.rd_in] = 1'b0;
      end
      if (bus.issue_ctrl) begin
         busy_nxt[bus.issue_rd_in] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
      if (bus.flush_ctrl) begin
         busy_nxt = '0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         for (int i = 0; i < GEN_REG_COUNT; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         if (wb_vld) begin
            regs_q[bus.rd_in] <= bus.writeData_in;
         end
         busy_q <= busy_nxt;
      end
   end

   always_comb begin
      for (int p = 0; p < READ_PORTS; p++) begin
         bus.regData_out[p] = regs_q[bus.rs_in[p]];
         bus.rsBusy_out[p]  = busy_q[bus.rs_in[p]];
         if ((BYPASS_EN != 0) && wb_vld && (bus.rs_in[p] == bus.rd_in)) begin
            bus.regData_out[p] = bus.writeData_in;
            bus.rsBusy_out[p]  = 1'b0;
         end
         if (bus.rs_in[p] == '0) begin
            bus.regData_out[p] = '0;
            bus.rsBusy_out[p]  = 1'b0;
         end
      end
   end

   always_comb begin
      busy_cnt = '0;
      for (int i = 0; i < GEN_REG_COUNT; i++) begin
         busy_cnt = busy_cnt + {{ADDR_W{1'b0}}, busy_q[i]};
      end
   end

   assign bus.busyCount_out = busy_cnt;
endmodule

// File: doc/scoreboard_reg_file.md
SCOREBOARD_REG_FILE -- requirements
Module: scoreboard_reg_file

Interface
REQ-001 SHALL provide parameter DATA_WIDTH_POW, default 6, log2 of register width.
REQ-002 SHALL provide parameter DATA_WIDTH, default 1 << DATA_WIDTH_POW, register width in bits.
REQ-003 SHALL provide parameter GEN_REG_COUNT, default 32, number of general registers; it SHALL be a power of 2 and at least 2.
REQ-004 SHALL provide parameter READ_PORTS, default 2, number of independent read ports; legal range is 1 to 4.
REQ-005 SHALL provide parameter BYPASS_EN, default 1, which enables write-to-read forwarding in the same cycle when set to 1.
REQ-006 SHALL provide local parameter ADDR_W, equal to $clog2(GEN_REG_COUNT).
REQ-007 SHALL provide port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL provide port rs_in, input, READ_PORTS x ADDR_W: read address per port.
REQ-010 SHALL provide port regData_out, output, READ_PORTS x DATA_WIDTH: read data per port.
REQ-011 SHALL provide port rsBusy_out, output, READ_PORTS x 1: pending-write flag of the addressed register, per port.
REQ-012 SHALL provide port issue_ctrl, input, 1 bit: an instruction with destination issue_rd_in is issued this cycle.
REQ-013 SHALL provide port issue_rd_in, input, ADDR_W: destination register of the issuing instruction.
REQ-014 SHALL provide port regWrite_ctrl, input, 1 bit: writeback enable.
REQ-015 SHALL provide port rd_in, input, ADDR_W: writeback destination register.
REQ-016 SHALL provide port writeData_in, input, DATA_WIDTH: writeback data.
REQ-017 SHALL provide port flush_ctrl, input, 1 bit: clears all pending flags (pipeline flush).
REQ-018 SHALL provide port busyCount_out, output, ADDR_W+1 bits: number of registers currently marked busy.

Function
REQ-019 Reads SHALL be combinational: regData_out[p] = registers[rs_in[p]] with zero latency.
REQ-020 Register 0 SHALL always read as 0 and SHALL never be written or marked busy, regardless of regWrite_ctrl or issue_ctrl.
REQ-021 A writeback (regWrite_ctrl=1, rd_in!=0) SHALL update registers[rd_in] at the next rising edge.
REQ-022 With BYPASS_EN=1, when regWrite_ctrl=1, rd_in!=0 and rs_in[p]==rd_in, regData_out[p] SHALL equal writeData_in in the same cycle, and rsBusy_out[p] SHALL be 0.
REQ-023 With BYPASS_EN=0, same-cycle reads SHALL return the old register value and the old busy flag.
REQ-024 Each register other than register 0 SHALL have a busy bit, set at the edge after issue_ctrl=1 with issue_rd_in!=0.
REQ-025 A busy bit SHALL be cleared at the edge after a writeback to that register.
REQ-026 When issue and writeback target the same register in the same cycle, the busy bit SHALL end set (the new issue wins); the data write SHALL still occur.
REQ-027 Issue to a register that is already busy SHALL leave it busy (no error, no counting); one writeback clears it.
REQ-028 flush_ctrl=1 SHALL clear all busy bits at the next edge and SHALL override any same-cycle issue; a same-cycle writeback data write SHALL still occur.
REQ-029 rsBusy_out[p] SHALL be busy[rs_in[p]] except where REQ-020 or REQ-022 applies.
REQ-030 busyCount_out SHALL equal the population count of the registered busy bits (combinational from state; range 0..GEN_REG_COUNT-1).
REQ-031 All read ports SHALL be fully independent, and any ports may address the same register.

Reset
REQ-032 While reset=1 at a rising edge, all registers SHALL become 0 and all busy bits SHALL become 0; reset SHALL override write, issue and flush.
REQ-033 After reset, regData_out SHALL be all 0, rsBusy_out SHALL be all 0 and busyCount_out SHALL be 0.
REQ-034 Reset asserted with issues pending SHALL discard them, and the first cycle after reset SHALL show busyCount_out=0.

Verification
REQ-035 Bench SHALL cover: reset, then write 0xDEAD_BEEF to x5; next cycle rs_in[0]=5 -> regData_out[0]=0xDEADBEEF, rsBusy_out[0]=0.
REQ-036 Bench SHALL cover: write 0x1234 to x0 with issue_rd_in=0 -> x0 reads 0, busyCount_out=0.
REQ-037 Bench SHALL cover: issue x7, then rs_in[1]=7 -> rsBusy_out[1]=1 and busyCount_out=1; writeback x7=0x55 with rs_in[1]=7 in the same cycle -> BYPASS_EN=1: data 0x55, busy 0; next cycle busyCount_out=0.
REQ-038 Bench SHALL cover: issue x3 and writeback x3=0x9 in the same cycle -> next cycle x3 reads 0x9 and rsBusy=1.
REQ-039 Bench SHALL cover: issue x1, x2, x4 -> busyCount_out=3; flush_ctrl=1 plus issue x6 in the same cycle -> next cycle busyCount_out=0.
REQ-040 Bench SHALL cover: registers loaded and x9 busy, then assert reset for one cycle during a writeback to x9 -> all reads 0, busyCount_out=0.
